// File: rtl/seq_detect_pkg.sv
// Shared types and constants for the programmable sequence detector.
// The match counter is built only when SEQ_DETECT_PROG_MATCH_CNT_EN is defined.
package seq_detect_pkg;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_FILL     = 2'd1,
        ST_ARMED    = 2'd2
    } state_t;

    // Pattern loaded at reset: detects 101011 (MSB of the active bits first).
    localparam logic [7:0] DEF_PAT = 8'b0010_1011;
    localparam int         DEF_LEN = 6;

    // Widest pattern the mask helper can describe.
    localparam int MASK_MAX = 64;

    // Ones in the low 'len' bit positions, zeros above.
    function automatic logic [MASK_MAX-1:0] len_mask(input int len);
        logic [MASK_MAX-1:0] m;
        m = '0;
        for (int i = 0; i < MASK_MAX; i++) begin
            if (i < len) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/seq_detect_hist.sv
// Serial history shift register plus a fill counter that saturates at PAT_W.
// Exposes the values the registers will take if the current bit is accepted,
// so the top can evaluate a match on the same edge.
module seq_detect_hist #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             acc,
    input  logic             x,
    output logic [PAT_W-1:0] hist_next,
    output logic [LEN_W-1:0] fill_next
);

    logic [PAT_W-1:0] hist;
    logic [LEN_W-1:0] fill;

    // Newest bit enters at bit 0; the oldest bit falls off the top.
    assign hist_next = (hist << 1) | PAT_W'(x);
    assign fill_next = (fill == LEN_W'(PAT_W)) ? fill : fill + LEN_W'(1);

    // Clear beats accept so a consumed (non-overlapping) match leaves nothing behind.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            hist <= '0;
            fill <= '0;
        end else if (acc) begin
            hist <= hist_next;
            fill <= fill_next;
        end
    end

endmodule

// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial bit-sequence detector.
// Pattern, active length and overlap mode are loaded with cfg_load; z is a
// registered one-cycle match pulse one clock after the accepting edge.
// Optional saturating match counter: define SEQ_DETECT_PROG_MATCH_CNT_EN.
// Handshake: x is consumed on every rising edge where x_vld=1, cfg_load=0,
// rst=0 and the detector is not disabled; there is no back-pressure.
module seq_detect_prog
    import seq_detect_pkg::*;
#(
    parameter int               PAT_W   = 8,
    parameter int               LEN_W   = $clog2(PAT_W + 1),
    parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(seq_detect_pkg::DEF_PAT),
    parameter int               DEF_LEN = seq_detect_pkg::DEF_LEN,
    parameter logic             DEF_OVL = 1'b0
`ifdef SEQ_DETECT_PROG_MATCH_CNT_EN
    ,
    parameter int               CNT_W   = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x,
    input  logic             x_vld,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pat,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_ovl,
    output logic             z,
    output logic             busy
`ifdef SEQ_DETECT_PROG_MATCH_CNT_EN
    ,
    output logic [CNT_W-1:0] match_cnt
`endif
);

    localparam state_t RST_STATE = (DEF_LEN == 0) ? ST_DISABLED : ST_FILL;

    state_t           state, state_next;
    logic [PAT_W-1:0] pat_r;
    logic [LEN_W-1:0] len_r;
    logic             ovl_r;
    logic [LEN_W-1:0] len_in;
    logic [PAT_W-1:0] mask;
    logic [PAT_W-1:0] hist_next;
    logic [LEN_W-1:0] fill_next;
    logic             accept;
    logic             match;
    logic             clr_hist;

    // Lengths beyond the register width are treated as the full width.
    assign len_in = (cfg_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : cfg_len;
    assign mask   = PAT_W'(len_mask(int'(len_r)));
    assign busy   = (state != ST_DISABLED);

    seq_detect_hist #(
        .PAT_W(PAT_W),
        .LEN_W(LEN_W)
    ) u_hist (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr_hist),
        .acc      (accept),
        .x        (x),
        .hist_next(hist_next),
        .fill_next(fill_next)
    );

    // Configuration registers: reset defaults, replaced on cfg_load.
    always_ff @(posedge clk) begin
        if (rst) begin
            pat_r <= DEF_PAT;
            len_r <= LEN_W'(DEF_LEN);
            ovl_r <= DEF_OVL;
        end else if (cfg_load) begin
            pat_r <= cfg_pat;
            len_r <= len_in;
            ovl_r <= cfg_ovl;
        end
    end

    // Bit acceptance, match compare and next-state selection.
    always_comb begin
        accept     = x_vld && !cfg_load && (state != ST_DISABLED);
        match      = 1'b0;
        clr_hist   = cfg_load;
        state_next = state;
        if (accept && (fill_next >= len_r) && (((hist_next ^ pat_r) & mask) == '0)) begin
            match = 1'b1;
        end
        if (match && !ovl_r) clr_hist = 1'b1;
        if (cfg_load) begin
            state_next = (len_in == '0) ? ST_DISABLED : ST_FILL;
        end else if (accept) begin
            if (match && !ovl_r)          state_next = ST_FILL;
            else if (fill_next >= len_r)  state_next = ST_ARMED;
            else                          state_next = ST_FILL;
        end
    end

    // State register and registered match pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RST_STATE;
            z     <= 1'b0;
        end else begin
            state <= state_next;
            z     <= match;
        end
    end

`ifdef SEQ_DETECT_PROG_MATCH_CNT_EN
    // Saturating match counter, cleared by reset and by a new configuration.
    always_ff @(posedge clk) begin
        if (rst || cfg_load) begin
            match_cnt <= '0;
        end else if (match && (match_cnt != '1)) begin
            match_cnt <= match_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_seq_detect_prog.sv
// Directed bench for seq_detect_prog: each driven cycle pushes its expected
// {busy, z} into exp_q; a monitor pops and compares one entry per clock.
module tb_seq_detect_prog;

    localparam int PAT_W = 8;
    localparam int LEN_W = 4;
    localparam int W     = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             x = 1'b0;
    logic             x_vld = 1'b0;
    logic             cfg_load = 1'b0;
    logic [PAT_W-1:0] cfg_pat = '0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic             cfg_ovl = 1'b0;
    logic             z;
    logic             busy;
`ifdef SEQ_DETECT_PROG_MATCH_CNT_EN
    logic [3:0]       match_cnt;
`endif

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_item;
    logic         exp_busy = 1'b1;
    int           n_tests = 0;
    int           n_fail  = 0;

    // Clock and reset block
    always #5 clk = ~clk;

`ifdef SEQ_DETECT_PROG_MATCH_CNT_EN
    seq_detect_prog #(.PAT_W(PAT_W), .CNT_W(4)) dut (
`else
    seq_detect_prog #(.PAT_W(PAT_W)) dut (
`endif
        .clk      (clk),
        .rst      (rst),
        .x        (x),
        .x_vld    (x_vld),
        .cfg_load (cfg_load),
        .cfg_pat  (cfg_pat),
        .cfg_len  (cfg_len),
        .cfg_ovl  (cfg_ovl),
        .z        (z),
        .busy     (busy)
`ifdef SEQ_DETECT_PROG_MATCH_CNT_EN
        ,
        .match_cnt(match_cnt)
`endif
    );

    // Monitor: one expected entry per rising edge, sampled 1 time unit later
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_item = exp_q.pop_front();
                n_tests++;
                if ({busy, z} !== exp_item) begin
                    n_fail++;
                    $display("FAIL busy_z at %0t: got busy=%b z=%b, expected busy=%b z=%b",
                             $time, busy, z, exp_item[1], exp_item[0]);
                end
            end
        end
    end

    // Driver tasks: inputs change on the falling edge
    task automatic cyc(input logic r, input logic l, input logic xi, input logic v,
                       input logic ez);
        @(negedge clk);
        rst = r; cfg_load = l; x = xi; x_vld = v;
        exp_q.push_back({exp_busy, ez});
    endtask

    task automatic do_reset();
        exp_busy = 1'b1;
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    // Load always presents x=1 with x_vld=1 to show the bit is ignored
    task automatic load(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] len,
                        input logic ovl);
        cfg_pat = p; cfg_len = len; cfg_ovl = ovl;
        exp_busy = (len != '0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic bit_in(input logic b, input logic ez);
        cyc(1'b0, 1'b0, b, 1'b1, ez);
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    // bits[n-1] is sent first; zs holds the expected pulse for each bit in the same order
    task automatic stream(input logic [15:0] bits, input int n, input logic [15:0] zs);
        for (int i = n - 1; i >= 0; i--) bit_in(bits[i], zs[i]);
    endtask

`ifdef SEQ_DETECT_PROG_MATCH_CNT_EN
    task automatic chk_cnt(input logic [3:0] exp_cnt);
        @(negedge clk);
        n_tests++;
        if (match_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL match_cnt: got %0d, expected %0d", match_cnt, exp_cnt);
        end
        rst = 1'b0; cfg_load = 1'b0; x_vld = 1'b0;
        exp_q.push_back({exp_busy, 1'b0});
    endtask
`endif

    initial begin
        // Default configuration 101011, non-overlapping
        do_reset();
        stream(16'b101011, 6, 16'b000001);
        stream(16'b10101101011, 11, 16'b00000100000);
`ifdef SEQ_DETECT_PROG_MATCH_CNT_EN
        chk_cnt(4'd2);
`endif

        // 101, overlap on then off
        load(8'b101, 4'd3, 1'b1);
        stream(16'b10101, 5, 16'b00101);
        load(8'b101, 4'd3, 1'b0);
        stream(16'b10101, 5, 16'b00100);

        // 1011 with invalid gaps between bits; z must drop after one cycle
        load(8'b1011, 4'd4, 1'b1);
        bit_in(1'b1, 1'b0); gap(3);
        bit_in(1'b0, 1'b0); gap(3);
        bit_in(1'b1, 1'b0); gap(3);
        bit_in(1'b1, 1'b1); gap(2);

        // Disabled: busy low, no pulses
        load(8'hFF, 4'd0, 1'b0);
        for (int i = 0; i < 50; i++) bit_in(1'($urandom_range(0, 1)), 1'b0);

        // Length 1 matches every 1, back to back
        load(8'h01, 4'd1, 1'b0);
        stream(16'b1101, 4, 16'b1101);
        // Reload while a match would occur: load wins
        load(8'h01, 4'd1, 1'b0);
        bit_in(1'b1, 1'b1);

        // Length above PAT_W clamps to the full 8 bits
        load(8'hA5, 4'd15, 1'b0);
        stream(16'hA5, 8, 16'h0001);

        // Reset mid-pattern restores 101011 and clears history
        do_reset();
        stream(16'b10101, 5, 16'b00000);
        do_reset();
        bit_in(1'b1, 1'b0);
        stream(16'b01011, 5, 16'b00001);

`ifdef SEQ_DETECT_PROG_MATCH_CNT_EN
        // Counter saturation at 15 with 19 matches, then clear on load
        load(8'h01, 4'd1, 1'b1);
        for (int i = 0; i < 19; i++) bit_in(1'b1, 1'b1);
        chk_cnt(4'd15);
        load(8'h01, 4'd1, 1'b1);
        chk_cnt(4'd0);
`endif

        gap(1);
        // Bounded drain of the expected queue
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d entries left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
